// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, step encoding and instruction classes for the control sequencer
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } step_e;

  typedef enum logic [4:0] {
    CL_RTYPE, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_NEGNOT, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic and_op;
    logic or_op;
    logic add;
    logic sub;
    logic mul;
    logic div;
    logic shr;
    logic shra;
    logic shl;
    logic ror_op;
    logic rol_op;
    logic neg;
    logic not_op;
  } alu_op_t;

  // Final execute step of each class; the step after it is T0 (or HALT).
  function automatic step_e last_step(instr_class_e cls);
    step_e s;
    case (cls)
      CL_RTYPE, CL_IMM, CL_LDI: s = ST_T5;
      CL_LD, CL_ST:             s = ST_T7;
      CL_MULDIV, CL_BR:         s = ST_T6;
      CL_NEGNOT, CL_JAL:        s = ST_T4;
      default:                  s = ST_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction/condition inputs and datapath control strobes
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        run;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, MARout, Read, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic read_mem, write_mem, CON_RESET, PCSave;

  modport master (
    input  ir, con_ff,
    output run,
    output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, MARout, Read, IncPC,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
    output read_mem, write_mem, CON_RESET, PCSave
  );

  modport slave (
    output ir, con_ff,
    input  run,
    input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, MARout, Read, IncPC,
    input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin,
    input  read_mem, write_mem, CON_RESET, PCSave
  );
endinterface

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - maps a 5-bit opcode to its instruction class and one-hot ALU operation
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e cls,
  output alu_op_t      alu_op
);

  always_comb begin
    cls    = CL_ILLEGAL;
    alu_op = '0;
    case (opcode)
      OP_LD:   begin cls = CL_LD;     alu_op.add    = 1'b1; end
      OP_LDI:  begin cls = CL_LDI;    alu_op.add    = 1'b1; end
      OP_ST:   begin cls = CL_ST;     alu_op.add    = 1'b1; end
      OP_ADD:  begin cls = CL_RTYPE;  alu_op.add    = 1'b1; end
      OP_SUB:  begin cls = CL_RTYPE;  alu_op.sub    = 1'b1; end
      OP_AND:  begin cls = CL_RTYPE;  alu_op.and_op = 1'b1; end
      OP_OR:   begin cls = CL_RTYPE;  alu_op.or_op  = 1'b1; end
      OP_ROR:  begin cls = CL_RTYPE;  alu_op.ror_op = 1'b1; end
      OP_ROL:  begin cls = CL_RTYPE;  alu_op.rol_op = 1'b1; end
      OP_SHR:  begin cls = CL_RTYPE;  alu_op.shr    = 1'b1; end
      OP_SHRA: begin cls = CL_RTYPE;  alu_op.shra   = 1'b1; end
      OP_SHL:  begin cls = CL_RTYPE;  alu_op.shl    = 1'b1; end
      OP_ADDI: begin cls = CL_IMM;    alu_op.add    = 1'b1; end
      OP_ANDI: begin cls = CL_IMM;    alu_op.and_op = 1'b1; end
      OP_ORI:  begin cls = CL_IMM;    alu_op.or_op  = 1'b1; end
      OP_DIV:  begin cls = CL_MULDIV; alu_op.div    = 1'b1; end
      OP_MUL:  begin cls = CL_MULDIV; alu_op.mul    = 1'b1; end
      OP_NEG:  begin cls = CL_NEGNOT; alu_op.neg    = 1'b1; end
      OP_NOT:  begin cls = CL_NEGNOT; alu_op.not_op = 1'b1; end
      OP_BR:   begin cls = CL_BR;     alu_op.add    = 1'b1; end
      OP_JR:   cls = CL_JR;
      OP_JAL:  cls = CL_JAL;
      OP_IN:   cls = CL_IN;
      OP_OUT:  cls = CL_OUT;
      OP_MFHI: cls = CL_MFHI;
      OP_MFLO: cls = CL_MFLO;
      OP_NOP:  cls = CL_NOP;
      OP_HALT: cls = CL_HALT;
      default: cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - step-counter control unit; define CU_ILLEGAL_TRAP_EN to halt on undefined opcodes
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master cs
);

  step_e        step_q, step_d;
  logic [4:0]   opcode_q, opcode_d;
  instr_class_e cls;
  alu_op_t      alu_op;
  logic         alu_en;
  logic         br_add;
  logic         stops;
  logic         unused_ir_bits;

  assign unused_ir_bits = ^cs.ir[26:0];

  cu_decode u_decode (
    .opcode (opcode_q),
    .cls    (cls),
    .alu_op (alu_op)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  assign stops = (cls == CL_HALT) || (cls == CL_ILLEGAL);
`else
  assign stops = (cls == CL_HALT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= ST_RST;
      opcode_q <= '0;
    end else begin
      step_q   <= step_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    opcode_d = (step_q == ST_T2) ? cs.ir[31:27] : opcode_q;
    step_d   = step_q;
    case (step_q)
      ST_RST:  step_d = ST_T0;
      ST_T0:   step_d = ST_T1;
      ST_T1:   step_d = ST_T2;
      ST_T2:   step_d = ST_T3;
      ST_HALT: step_d = ST_HALT;
      default: begin
        if (step_q == last_step(cls)) step_d = stops ? ST_HALT : ST_T0;
        else                          step_d = step_e'(step_q + 4'd1);
      end
    endcase
  end

  always_comb begin
    cs.run = 1'b1;
    cs.HIout = 1'b0; cs.LOout = 1'b0; cs.Zhighout = 1'b0; cs.Zlowout = 1'b0;
    cs.PCout = 1'b0; cs.MDRout = 1'b0; cs.INout = 1'b0; cs.Cout = 1'b0;
    cs.MARout = 1'b0; cs.Read = 1'b0; cs.IncPC = 1'b0;
    cs.Gra = 1'b0; cs.Grb = 1'b0; cs.Grc = 1'b0; cs.Rin = 1'b0; cs.Rout = 1'b0; cs.BAout = 1'b0;
    cs.HIin = 1'b0; cs.LOin = 1'b0; cs.PCin = 1'b0; cs.IRin = 1'b0; cs.Zin = 1'b0;
    cs.Yin = 1'b0; cs.MARin = 1'b0; cs.MDRin = 1'b0; cs.CONin = 1'b0; cs.OUT_Portin = 1'b0;
    cs.read_mem = 1'b0; cs.write_mem = 1'b0; cs.CON_RESET = 1'b0; cs.PCSave = 1'b0;
    alu_en = 1'b0;
    br_add = 1'b0;

    case (step_q)
      ST_RST: cs.CON_RESET = 1'b1;
      ST_T0: begin cs.IncPC = 1'b1; cs.MARin = 1'b1; cs.PCin = 1'b1; end
      ST_T1: begin cs.read_mem = 1'b1; cs.Read = 1'b1; cs.MDRin = 1'b1; end
      ST_T2: begin cs.MDRout = 1'b1; cs.IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CL_RTYPE, CL_IMM: begin cs.Grb = 1'b1; cs.Rout = 1'b1; cs.Yin = 1'b1; end
          CL_LD, CL_LDI, CL_ST: begin cs.Grb = 1'b1; cs.BAout = 1'b1; cs.Yin = 1'b1; end
          CL_MULDIV: begin cs.Gra = 1'b1; cs.Rout = 1'b1; cs.Yin = 1'b1; end
          CL_NEGNOT: begin cs.Grb = 1'b1; cs.Rout = 1'b1; cs.Zin = 1'b1; alu_en = 1'b1; end
          CL_BR:     begin cs.Gra = 1'b1; cs.Rout = 1'b1; cs.CONin = 1'b1; end
          CL_JR:     begin cs.Gra = 1'b1; cs.Rout = 1'b1; cs.PCin = 1'b1; end
          // R8 is selected by the datapath when PCSave is high.
          CL_JAL:    begin cs.PCout = 1'b1; cs.PCSave = 1'b1; cs.Rin = 1'b1; end
          CL_IN:     begin cs.INout = 1'b1; cs.Gra = 1'b1; cs.Rin = 1'b1; end
          CL_OUT:    begin cs.Gra = 1'b1; cs.Rout = 1'b1; cs.OUT_Portin = 1'b1; end
          CL_MFHI:   begin cs.HIout = 1'b1; cs.Gra = 1'b1; cs.Rin = 1'b1; end
          CL_MFLO:   begin cs.LOout = 1'b1; cs.Gra = 1'b1; cs.Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_RTYPE: begin cs.Grc = 1'b1; cs.Rout = 1'b1; cs.Zin = 1'b1; alu_en = 1'b1; end
          CL_IMM, CL_LD, CL_LDI, CL_ST: begin cs.Cout = 1'b1; cs.Zin = 1'b1; alu_en = 1'b1; end
          CL_MULDIV: begin cs.Grb = 1'b1; cs.Rout = 1'b1; cs.Zin = 1'b1; alu_en = 1'b1; end
          CL_NEGNOT: begin cs.Zlowout = 1'b1; cs.Gra = 1'b1; cs.Rin = 1'b1; end
          CL_BR:     begin cs.PCout = 1'b1; cs.Yin = 1'b1; end
          CL_JAL:    begin cs.Gra = 1'b1; cs.Rout = 1'b1; cs.PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_RTYPE, CL_IMM, CL_LDI: begin cs.Zlowout = 1'b1; cs.Gra = 1'b1; cs.Rin = 1'b1; end
          CL_LD, CL_ST: begin cs.Zlowout = 1'b1; cs.MARin = 1'b1; end
          CL_MULDIV:    begin cs.Zlowout = 1'b1; cs.LOin = 1'b1; end
          CL_BR:        begin cs.Cout = 1'b1; cs.Zin = 1'b1; br_add = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CL_LD:     begin cs.read_mem = 1'b1; cs.Read = 1'b1; cs.MDRin = 1'b1; end
          CL_ST:     begin cs.Gra = 1'b1; cs.Rout = 1'b1; cs.MDRin = 1'b1; end
          CL_MULDIV: begin cs.Zhighout = 1'b1; cs.HIin = 1'b1; end
          CL_BR:     begin cs.Zlowout = cs.con_ff; cs.PCin = cs.con_ff; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CL_LD: begin cs.MDRout = 1'b1; cs.Gra = 1'b1; cs.Rin = 1'b1; end
          // A reset arriving in the store cycle must not let the write through.
          CL_ST: cs.write_mem = !reset;
          default: ;
        endcase
      end
      ST_HALT: cs.run = 1'b0;
      default: ;
    endcase

    cs.AND  = alu_en & alu_op.and_op;
    cs.OR   = alu_en & alu_op.or_op;
    cs.ADD  = (alu_en & alu_op.add) | br_add;
    cs.SUB  = alu_en & alu_op.sub;
    cs.MUL  = alu_en & alu_op.mul;
    cs.DIV  = alu_en & alu_op.div;
    cs.SHR  = alu_en & alu_op.shr;
    cs.SHRA = alu_en & alu_op.shra;
    cs.SHL  = alu_en & alu_op.shl;
    cs.ROR  = alu_en & alu_op.ror_op;
    cs.ROL  = alu_en & alu_op.rol_op;
    cs.NEG  = alu_en & alu_op.neg;
    cs.NOT  = alu_en & alu_op.not_op;
  end

endmodule
